// File: rtl/pc_gen.sv
// Program-counter generator: boot FSM, valid/ready fetch handshake, prioritised EX redirects with a
// redirect latch that survives stalls, and a fetch-issue counter. Optional misaligned-target trap: PC_MISALIGN_TRAP_EN.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              INC       = 4,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [XLEN-1:0]  redir_target,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc_seq,
  output logic             redir_pending,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign,
  output logic [XLEN-1:0]  bad_target
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic [XLEN-1:0]   eff;
  logic              take_en;
  logic [XLEN-1:0]   take_addr;

  // JALR rule: bit0 of any redirect target is ignored.
  assign eff    = {redir_target[XLEN-1:1], 1'b0};
  assign accept = pc_valid_q & fetch_ready & ~stall;

  always_comb begin
    state_d    = state_q;
    pc_valid_d = pc_valid_q;
    pend_d     = pend_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    take_en    = 1'b0;
    take_addr  = eff;
    if (accept) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (redir_valid && !stall) begin
          take_en = 1'b1;
        end else if (redir_valid) begin
          tgt_d   = eff;
          pend_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (redir_valid) tgt_d = eff;
        end else begin
          take_en   = 1'b1;
          take_addr = redir_valid ? eff : tgt_q;
          pend_d    = 1'b0;
          state_d   = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
  logic [XLEN-1:0] bad_q, bad_d;

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    bad_d = bad_q;
    if (take_en) begin
      if (take_addr[1]) begin
        pc_d  = TRAP_VEC;
        mis_d = 1'b1;
        bad_d = take_addr;
      end else begin
        pc_d = take_addr;
      end
    end else if (state_q == RUN && accept && !redir_valid) begin
      pc_d = pc_q + XLEN'(INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
      bad_q <= '0;
    end else begin
      mis_q <= mis_d;
      bad_q <= bad_d;
    end
  end

  assign misalign   = mis_q;
  assign bad_target = bad_q;
`else
  always_comb begin
    pc_d = pc_q;
    if (take_en) pc_d = take_addr;
    else if (state_q == RUN && accept && !redir_valid) pc_d = pc_q + XLEN'(INC);
  end

  assign misalign   = 1'b0;
  assign bad_target = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      tgt_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      pend_q     <= pend_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign pc_seq        = pc_q + XLEN'(INC);
  assign redir_pending = pend_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen against a cycle-level reference model; a CNT_W=4 twin checks counter wrap.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst, stall, redir_valid, fetch_ready;
  logic [31:0] redir_target;
  logic [31:0] pc, pc_seq, bad_target, pc4, pc_seq4, bad_target4;
  logic        pc_valid, redir_pending, misalign, pc_valid4, redir_pending4, misalign4;
  logic [31:0] fetch_cnt;
  logic [3:0]  fetch_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_booted, m_pending, m_mis;
  logic [31:0] m_pc, m_latched, m_bad, m_cnt;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid), .redir_target(redir_target),
    .fetch_ready(fetch_ready), .pc(pc), .pc_valid(pc_valid), .pc_seq(pc_seq),
    .redir_pending(redir_pending), .fetch_cnt(fetch_cnt), .misalign(misalign), .bad_target(bad_target)
  );

  pc_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid), .redir_target(redir_target),
    .fetch_ready(fetch_ready), .pc(pc4), .pc_valid(pc_valid4), .pc_seq(pc_seq4),
    .redir_pending(redir_pending4), .fetch_cnt(fetch_cnt4), .misalign(misalign4), .bad_target(bad_target4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_pending = 0; m_mis = 0;
    m_pc = 32'h0; m_latched = 32'h0; m_bad = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic model_go(input logic [31:0] d);
`ifdef PC_MISALIGN_TRAP_EN
    if (d[1]) begin
      m_pc = 32'h100; m_mis = 1; m_bad = d;
    end else m_pc = d;
`else
    m_pc = d;
`endif
  endtask

  task automatic model_edge();
    logic [31:0] eff;
    bit acc;
    if (rst) begin
      model_reset();
      return;
    end
    m_mis = 0;
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    eff = redir_target & ~32'h1;
    acc = fetch_ready && !stall;
    if (acc) m_cnt = m_cnt + 1;
    if (m_pending) begin
      if (stall) begin
        if (redir_valid) m_latched = eff;
      end else begin
        model_go(redir_valid ? eff : m_latched);
        m_pending = 0;
      end
    end else if (redir_valid && !stall) model_go(eff);
    else if (redir_valid) begin
      m_latched = eff; m_pending = 1;
    end else if (acc) m_pc = m_pc + 4;
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_valid", {31'b0, pc_valid}, {31'b0, m_booted});
    check("pc_seq", pc_seq, m_pc + 32'd4);
    check("redir_pending", {31'b0, redir_pending}, {31'b0, m_pending});
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("fetch_cnt4", {28'b0, fetch_cnt4}, {28'b0, m_cnt[3:0]});
    check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    check("bad_target", bad_target, m_bad);
    check("pc_w4", pc4, m_pc);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit s, input bit rv, input logic [31:0] t, input bit fr);
    stall = s; redir_valid = rv; redir_target = t; fetch_ready = fr;
    cycle();
  endtask

  initial begin
    rst = 1'b1; stall = 0; redir_valid = 0; redir_target = 0; fetch_ready = 0;
    model_reset();
    #3;
    check_all();
    cycle(); cycle();
    rst = 1'b0;
    // boot: one idle cycle, then 0,4,8 with count 1,2,3
    drive(0, 0, 0, 1);
    check("boot_pc", pc, 32'h0);
    drive(0, 0, 0, 1); drive(0, 0, 0, 1); drive(0, 0, 0, 1);
    check("boot_step", pc, 32'hc);
    check("boot_cnt", fetch_cnt, 32'd3);
    // async reset mid-run at pc=0x40
    drive(0, 1, 32'h40, 1);
    check("pc_40", pc, 32'h40);
    rst = 1'b1; #1;
    model_reset();
    check("async_rst_pc", pc, 32'h0);
    check_all();
    cycle();
    rst = 1'b0;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    check("pc_10", pc, 32'h10);
    // stall 3, then backpressure 2
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0);
    check("held_pc", pc, 32'h10);
    drive(0, 0, 0, 1);
    check("resume_pc", pc, 32'h14);
    // unstalled redirect from 0x20
    drive(0, 1, 32'h20, 1);
    drive(0, 1, 32'h101, 1);
    check("redir_pc", pc, 32'h100);
    // redirects during stall, newest wins
    drive(1, 1, 32'h200, 1);
    drive(1, 1, 32'h300, 1);
    check("pending", {31'b0, redir_pending}, 32'h1);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("hold_release_pc", pc, 32'h300);
    check("hold_release_pend", {31'b0, redir_pending}, 32'h0);
    // PC wrap
    drive(0, 1, 32'hFFFF_FFFC, 1);
    drive(0, 0, 0, 1);
    check("wrap_pc", pc, 32'h0);
    check("wrap_seq", pc_seq, 32'h4);
    // misaligned target
    drive(0, 1, 32'h102, 1);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc", pc, 32'h100);
    check("mis_pulse", {31'b0, misalign}, 32'h1);
    check("mis_bad", bad_target, 32'h102);
`else
    check("mis_pc", pc, 32'h102);
    check("mis_pulse", {31'b0, misalign}, 32'h0);
`endif
    drive(0, 0, 0, 1);
    check("mis_clear", {31'b0, misalign}, 32'h0);
    // random phase
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = ($urandom_range(1) == 0) ? $urandom : ($urandom_range(255) & 32'h3ff);
      if ($urandom_range(99) == 0) begin
        rst = 1'b1; #1;
        model_reset();
        check_all();
        cycle();
        rst = 1'b0;
      end
      drive($urandom_range(9) < 3, $urandom_range(99) < 15, t, $urandom_range(9) < 7);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the pipelined RV32I core. It replaces the plain PC register with a small boot state machine and a valid/ready fetch handshake to instruction memory. It also handles prioritised redirects from EX (branch/jump), a latched redirect that survives stalls, and a fetch-issue counter. It sits at the head of the IF stage and drives the instruction-memory address and the IF/ID PC.

Parameters:
XLEN, 32, width of PC and target datapath
RESET_VEC, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential PC increment in bytes
TRAP_VEC, 32'h0000_0100, redirect destination for misaligned targets (used only with optional feature)
CNT_W, 32, width of fetch-issue counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hazard-unit stall; freezes PC when 1
redir_valid  in  1  EX-stage redirect request (taken branch/jump)
redir_target  in  XLEN  redirect target address
fetch_ready  in  1  imem accepts the address on pc this cycle
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a valid fetch request
pc_seq  out  XLEN  pc + INC, combinational
redir_pending  out  1  a redirect is latched awaiting stall release
fetch_cnt  out  CNT_W  number of accepted fetches since reset
misalign  out  1  one-cycle pulse: redirect target misaligned (optional feature)
bad_target  out  XLEN  last misaligned target captured (optional feature)

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_VEC, pc_valid=0, redir_pending=0, pending target=0, fetch_cnt=0, misalign=0, bad_target=0, state=BOOT.
- States: BOOT, RUN, HOLD.
- BOOT: pc_valid=0. Next edge moves to RUN unconditionally; pc stays RESET_VEC. First fetch request is the 2nd cycle after rst deasserts.
- RUN: pc_valid=1.
- Definition: accept = pc_valid & fetch_ready & !stall.
- fetch_cnt increments by 1 on accept and wraps modulo 2^CNT_W.
- Effective target: eff = redir_target with bit0 cleared (JALR rule).
- Next-PC priority in RUN, evaluated each edge, highest first:
  1. redir_valid & !stall -> pc <= eff, regardless of fetch_ready.
  2. redir_valid & stall -> latch eff, redir_pending=1, go to HOLD; pc unchanged.
  3. accept -> pc <= pc + INC, modulo 2^XLEN. 0xFFFF_FFFC wraps to 0x0000_0000.
  4. Otherwise pc holds; covers stall, or fetch_ready=0 without redirect.
- HOLD: pc_valid=1, redir_pending=1, and pc still drives imem.
  - accept in HOLD does not advance pc, but still counts in fetch_cnt.
  - new redir_valid overwrites the latched target; the newest redirect wins.
  - When stall=0: pc <= latched target (or the new eff if redir_valid is also asserted the same cycle), redir_pending=0, return to RUN.
- pc_seq is purely combinational from pc. It is valid in every state.
- Redirect latency: 1 edge from an unstalled redir_valid to the new pc.

Optional Feature:
PC_MISALIGN_TRAP_EN
- Defined: when a redirect applies with eff[1]=1, pc <= TRAP_VEC instead of eff. misalign pulses high for exactly the cycle after, and bad_target captures eff. This also applies to a target latched in HOLD, checked at release.
- Not defined: eff is used unchanged, including bit1. misalign is tied 0, bad_target is tied 0, and no check logic is synthesised.

Test Plan:
- Reset/boot: assert rst mid-run with pc=0x40 -> pc=0 immediately, pc_valid=0 for one cycle after release, then 1. With fetch_ready=1 and no stall, pc steps 0,4,8 and fetch_cnt steps 1,2,3.
- Stall and backpressure: at pc=0x10, raise stall for 3 cycles, then drop stall and drop fetch_ready for 2 cycles -> pc holds at 0x10 throughout and fetch_cnt does not change. pc=0x14 on the edge after both are clear.
- Redirect unstalled: at pc=0x20, redir_valid with target 0x101 -> next pc=0x100, and fetch_cnt counts only the accepted fetch at 0x20.
- Redirect during stall: stall=1, redir 0x200, then redir 0x300 one cycle later, release stall 2 cycles later -> redir_pending=1 across the stall, then pc=0x300 and redir_pending=0 the edge after release.
- Wrap: force pc to 0xFFFF_FFFC by redirect and accept -> pc=0x0, pc_seq=0x4. Set fetch_cnt to all-ones via a CNT_W=4 instance -> it wraps to 0.
- PC_MISALIGN_TRAP_EN defined: redirect target 0x102 -> pc=0x100 (TRAP_VEC), misalign=1 for one cycle, bad_target=0x102. With the macro undefined, the same stimulus gives pc=0x102 and misalign=0.
